// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the wide-operation ALU sequencer:
//   - ALU op codes as seen on the shared 32-bit combinational ALU
//   - sequencer state encoding
//   - NZCV bit positions inside the 4-bit flag vectors
//   - map_pass(): per-pass ALU op/carry-in selection for chained 64-bit ops
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

    // ALU op codes
    localparam logic [3:0] AND_L = 4'b0000;
    localparam logic [3:0] AND_B = 4'b0001;
    localparam logic [3:0] OR_L  = 4'b0010;
    localparam logic [3:0] OR_B  = 4'b0011;
    localparam logic [3:0] XOR   = 4'b0100;
    localparam logic [3:0] XOR_B = 4'b0101;
    localparam logic [3:0] ADD   = 4'b0111;
    localparam logic [3:0] SUB   = 4'b1000;
    localparam logic [3:0] ADC   = 4'b1001;
    localparam logic [3:0] SBC   = 4'b1010;

    // Bit positions of N, Z, C, V inside a 4-bit NZCV vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // Which word of a (possibly wide) operation the ALU is working on
    typedef enum logic {
        PASS_LO = 1'b0,
        PASS_HI = 1'b1
    } pass_t;

    // What the sequencer presents to the ALU control inputs for one pass
    typedef struct packed {
        logic [3:0] op;
        logic       cin;
    } alu_drive_t;

    // True for the carry-producing arithmetic ops (ADD..SBC)
    function automatic logic is_arith(input logic [3:0] op);
        return (op >= ADD) && (op <= SBC);
    endfunction

    // Select ALU op and carry-in for one pass.
    // The low pass of ADD/SUB starts the chain with no carry; ADC/SBC feed in
    // the architectural C. The high pass always continues the chain with the
    // carry/borrow out of the low pass, so ADD/ADC become ADC and SUB/SBC
    // become SBC. Every other op runs unchanged with carry-in cleared.
    function automatic alu_drive_t map_pass(
        input logic [3:0] op,
        input pass_t      pass,
        input logic       c_arch,
        input logic       cout_lo
    );
        alu_drive_t d;
        d.op  = op;
        d.cin = 1'b0;
        case (op)
            ADD: begin
                if (pass == PASS_LO) begin
                    d.op  = ADD;
                    d.cin = 1'b0;
                end else begin
                    d.op  = ADC;
                    d.cin = cout_lo;
                end
            end
            ADC: begin
                d.op = ADC;
                if (pass == PASS_LO) begin
                    d.cin = c_arch;
                end else begin
                    d.cin = cout_lo;
                end
            end
            SUB: begin
                if (pass == PASS_LO) begin
                    d.op  = SUB;
                    d.cin = 1'b0;
                end else begin
                    d.op  = SBC;
                    d.cin = cout_lo;
                end
            end
            SBC: begin
                d.op = SBC;
                if (pass == PASS_LO) begin
                    d.cin = c_arch;
                end else begin
                    d.cin = cout_lo;
                end
            end
            default: begin
                d.op  = op;
                d.cin = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage : alu_ctrl_pkg

// File: rtl/alu_wide_sequencer.sv
// -----------------------------------------------------------------------------
// alu_wide_sequencer
// Multi-cycle controller in front of a shared 32-bit combinational ALU.
// Runs 32-bit ops in one ALU pass and 64-bit ops in two passes (low word,
// then high word with carry/borrow chained), owns the architectural NZCV
// register and returns result + flags over a valid/ready response channel.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op/wide/setf      ALU op, 64-bit select, update-NZCV select
//   req_a, req_b          64-bit operands (only low 32 bits used when narrow)
//   alu_a/b/op/cin        drive to the shared ALU
//   alu_o/n/z/v/cout      result and flags back from the ALU
//   rsp_valid/rsp_ready   response handshake
//   rsp_result            {hi, lo} result; upper word zero when narrow
//   rsp_flags             NZCV composed for this op (independent of setf)
//   flags                 architectural NZCV register
//
// Vectors are declared descending; what the ALU documentation calls bit 0
// (the MSB) is the top index here, so numeric values are identical.
// -----------------------------------------------------------------------------
module alu_wide_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter logic [3:0] IDLE_OP = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic        req_wide,
    input  logic        req_setf,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic        alu_cin,
    input  logic [31:0] alu_o,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        alu_cout,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic [3:0]  flags
);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_op;
    logic        r_wide;
    logic        r_setf;
    logic [63:0] r_a;
    logic [63:0] r_b;

    logic [31:0] r_lo_word;
    logic        r_z_lo;
    logic        r_cout_lo;

    logic [63:0] r_rsp_result;
    logic [3:0]  r_rsp_flags;
    logic [3:0]  r_flags;
    logic        r_req_ready;
    logic        r_rsp_valid;

    alu_drive_t  w_drv;
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic [63:0] w_res;
    logic [3:0]  w_nzcv;
    logic        w_enter_resp;
    logic        w_accept;

    assign w_accept = (r_state == ST_IDLE) && req_valid;

    // Next-state logic for the pass sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = ST_LO;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LO: begin
                if (r_wide) begin
                    w_state_nxt = ST_HI;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_HI: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ALU drive: decoded from registered state/operands only, idle otherwise
    always_comb begin
        w_drv.op  = IDLE_OP;
        w_drv.cin = 1'b0;
        w_alu_a   = 32'h0000_0000;
        w_alu_b   = 32'h0000_0000;
        case (r_state)
            ST_LO: begin
                w_drv   = map_pass(r_op, PASS_LO, r_flags[FLAG_C], 1'b0);
                w_alu_a = r_a[31:0];
                w_alu_b = r_b[31:0];
            end
            ST_HI: begin
                w_drv   = map_pass(r_op, PASS_HI, r_flags[FLAG_C], r_cout_lo);
                w_alu_a = r_a[63:32];
                w_alu_b = r_b[63:32];
            end
            default: begin
                w_drv.op  = IDLE_OP;
                w_drv.cin = 1'b0;
                w_alu_a   = 32'h0000_0000;
                w_alu_b   = 32'h0000_0000;
            end
        endcase
    end

    assign alu_a   = w_alu_a;
    assign alu_b   = w_alu_b;
    assign alu_op  = w_drv.op;
    assign alu_cin = w_drv.cin;

    // Compose the response from the pass that finishes this cycle.
    // Logic ops produce no carry, so C keeps the architectural value.
    // A wide result is zero only if both halves were zero.
    always_comb begin
        w_res        = r_rsp_result;
        w_nzcv       = r_rsp_flags;
        w_enter_resp = 1'b0;
        if (r_state == ST_LO) begin
            w_res          = {32'h0000_0000, alu_o};
            w_nzcv[FLAG_N] = alu_n;
            w_nzcv[FLAG_Z] = alu_z;
            w_nzcv[FLAG_C] = is_arith(r_op) ? alu_cout : r_flags[FLAG_C];
            w_nzcv[FLAG_V] = alu_v;
            w_enter_resp   = !r_wide;
        end else if (r_state == ST_HI) begin
            w_res          = {alu_o, r_lo_word};
            w_nzcv[FLAG_N] = alu_n;
            w_nzcv[FLAG_Z] = r_z_lo & alu_z;
            w_nzcv[FLAG_C] = is_arith(r_op) ? alu_cout : r_flags[FLAG_C];
            w_nzcv[FLAG_V] = alu_v;
            w_enter_resp   = 1'b1;
        end else begin
            w_res        = r_rsp_result;
            w_nzcv       = r_rsp_flags;
            w_enter_resp = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch: operands and controls captured on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= 4'b0000;
            r_wide <= 1'b0;
            r_setf <= 1'b0;
            r_a    <= 64'h0;
            r_b    <= 64'h0;
        end else if (w_accept) begin
            r_op   <= req_op;
            r_wide <= req_wide;
            r_setf <= req_setf;
            r_a    <= req_a;
            r_b    <= req_b;
        end else begin
            r_op   <= r_op;
            r_wide <= r_wide;
            r_setf <= r_setf;
            r_a    <= r_a;
            r_b    <= r_b;
        end
    end

    // Low-pass capture: what the high pass and flag composition still need
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo_word <= 32'h0000_0000;
            r_z_lo    <= 1'b0;
            r_cout_lo <= 1'b0;
        end else if (r_state == ST_LO) begin
            r_lo_word <= alu_o;
            r_z_lo    <= alu_z;
            r_cout_lo <= alu_cout;
        end else begin
            r_lo_word <= r_lo_word;
            r_z_lo    <= r_z_lo;
            r_cout_lo <= r_cout_lo;
        end
    end

    // Response registers and architectural flags, loaded on entry to RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_result <= 64'h0;
            r_rsp_flags  <= 4'b0000;
            r_flags      <= 4'b0000;
        end else if (w_enter_resp) begin
            r_rsp_result <= w_res;
            r_rsp_flags  <= w_nzcv;
            r_flags      <= r_setf ? w_nzcv : r_flags;
        end else begin
            r_rsp_result <= r_rsp_result;
            r_rsp_flags  <= r_rsp_flags;
            r_flags      <= r_flags;
        end
    end

    // Handshake outputs registered from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= (w_state_nxt == ST_RESP);
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign flags      = r_flags;

endmodule : alu_wide_sequencer

// File: tb/tb_alu_wide_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_wide_sequencer
// Directed bench: a behavioural 32-bit ALU closes the loop around the
// sequencer; each step compares DUT outputs with hand-computed values.
// Latency is counted in rising edges including the acceptance edge.
// -----------------------------------------------------------------------------
module tb_alu_wide_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic        req_wide;
    logic        req_setf;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic        alu_cin;
    logic [31:0] alu_o;
    logic        alu_n;
    logic        alu_z;
    logic        alu_v;
    logic        alu_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [3:0]  flags;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_wide_sequencer #(.IDLE_OP(4'b1111)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_wide   (req_wide),
        .req_setf   (req_setf),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_cin    (alu_cin),
        .alu_o      (alu_o),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .alu_v      (alu_v),
        .alu_cout   (alu_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .flags      (flags)
    );

    // Behavioural model of the shared ALU (cout on SUB/SBC is borrow)
    logic [32:0] t;
    always_comb begin
        t        = 33'h0;
        alu_v    = 1'b0;
        case (alu_op)
            4'b0001: t = {1'b0, alu_a & alu_b};
            4'b0011: t = {1'b0, alu_a | alu_b};
            4'b0101: t = {1'b0, alu_a ^ alu_b};
            4'b0111: t = {1'b0, alu_a} + {1'b0, alu_b};
            4'b1001: t = {1'b0, alu_a} + {1'b0, alu_b} + {32'h0, alu_cin};
            4'b1000: t = {1'b0, alu_a} - {1'b0, alu_b};
            4'b1010: t = {1'b0, alu_a} - {1'b0, alu_b} - {32'h0, alu_cin};
            default: t = {1'b0, alu_a};
        endcase
        if (alu_op == 4'b0111 || alu_op == 4'b1001) begin
            alu_v = (alu_a[31] == alu_b[31]) && (t[31] != alu_a[31]);
        end else if (alu_op == 4'b1000 || alu_op == 4'b1010) begin
            alu_v = (alu_a[31] != alu_b[31]) && (t[31] != alu_a[31]);
        end else begin
            alu_v = 1'b0;
        end
    end
    assign alu_o    = t[31:0];
    assign alu_cout = t[32];
    assign alu_n    = t[31];
    assign alu_z    = (t[31:0] == 32'h0);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request while the DUT is idle; returns one edge later (in LO)
    task automatic accept(input logic [3:0] op, input logic wide, input logic setf,
                          input logic [63:0] a, input logic [63:0] b, input string tag);
        req_op    = op;
        req_wide  = wide;
        req_setf  = setf;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        chk({tag, "_req_ready"}, {63'h0, req_ready}, 64'h1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_drop"}, {63'h0, rsp_valid}, 64'h0);
        chk({tag, "_req_ready_back"}, {63'h0, req_ready}, 64'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'b0000;
        req_wide  = 1'b0;
        req_setf  = 1'b0;
        req_a     = 64'h0;
        req_b     = 64'h0;
        rsp_ready = 1'b0;
        #12;
        chk("rst_req_ready",  {63'h0, req_ready}, 64'h1);
        chk("rst_rsp_valid",  {63'h0, rsp_valid}, 64'h0);
        chk("rst_rsp_result", rsp_result, 64'h0);
        chk("rst_rsp_flags",  {60'h0, rsp_flags}, 64'h0);
        chk("rst_flags",      {60'h0, flags}, 64'h0);
        chk("rst_alu_op",     {60'h0, alu_op}, 64'hF);
        chk("rst_alu_a",      {32'h0, alu_a}, 64'h0);
        chk("rst_alu_cin",    {63'h0, alu_cin}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1: wide ADD with carry across the word boundary
        accept(4'b0111, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, "t1");
        chk("t1_lo_op",  {60'h0, alu_op}, 64'h7);
        chk("t1_lo_cin", {63'h0, alu_cin}, 64'h0);
        chk("t1_lo_a",   {32'h0, alu_a}, 64'hFFFF_FFFF);
        chk("t1_req_ready_busy", {63'h0, req_ready}, 64'h0);
        step();
        chk("t1_hi_op",  {60'h0, alu_op}, 64'h9);
        chk("t1_hi_cin", {63'h0, alu_cin}, 64'h1);
        chk("t1_hi_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        step();
        chk("t1_lat3_rsp_valid", {63'h0, rsp_valid}, 64'h1);
        chk("t1_result", rsp_result, 64'h0000_0001_0000_0000);
        chk("t1_rsp_flags", {60'h0, rsp_flags}, 64'h0);
        chk("t1_flags", {60'h0, flags}, 64'h0);
        chk("t1_resp_alu_op", {60'h0, alu_op}, 64'hF);
        handshake("t1");

        // 2: wide SUB 0-1, borrow chained into the high word
        accept(4'b1000, 1'b1, 1'b1, 64'h0, 64'h1, "t2");
        step();
        chk("t2_hi_op",  {60'h0, alu_op}, 64'hA);
        chk("t2_hi_cin", {63'h0, alu_cin}, 64'h1);
        step();
        chk("t2_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2_rsp_flags", {60'h0, rsp_flags}, 64'hA);
        chk("t2_flags", {60'h0, flags}, 64'hA);
        handshake("t2");

        // 3: narrow ADC using architectural C=1, setf=0
        accept(4'b1001, 1'b0, 1'b0, 64'h5, 64'h6, "t3");
        chk("t3_lo_op",  {60'h0, alu_op}, 64'h9);
        chk("t3_lo_cin", {63'h0, alu_cin}, 64'h1);
        chk("t3_lo_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        step();
        chk("t3_lat2_rsp_valid", {63'h0, rsp_valid}, 64'h1);
        chk("t3_result", rsp_result, 64'hC);
        chk("t3_rsp_flags", {60'h0, rsp_flags}, 64'h0);
        chk("t3_flags_kept", {60'h0, flags}, 64'hA);
        handshake("t3");

        // 4: wide bitwise AND, setf=0: Z from both halves, C kept
        accept(4'b0001, 1'b1, 1'b0, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, "t4");
        step();
        chk("t4_hi_op", {60'h0, alu_op}, 64'h1);
        step();
        chk("t4_result", rsp_result, 64'h0);
        chk("t4_rsp_flags", {60'h0, rsp_flags}, 64'h6);
        chk("t4_flags_kept", {60'h0, flags}, 64'hA);
        handshake("t4");

        // 5: narrow SUB 5-3 held in RESP while a new request waits
        accept(4'b1000, 1'b0, 1'b1, 64'h5, 64'h3, "t5");
        step();
        req_op    = 4'b1000;
        req_wide  = 1'b0;
        req_setf  = 1'b1;
        req_a     = 64'h1;
        req_b     = 64'h2;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_hold_rsp_valid", {63'h0, rsp_valid}, 64'h1);
            chk("t5_hold_result", rsp_result, 64'h2);
            chk("t5_hold_rsp_flags", {60'h0, rsp_flags}, 64'h0);
            chk("t5_hold_req_ready", {63'h0, req_ready}, 64'h0);
            step();
        end
        chk("t5_flags", {60'h0, flags}, 64'h0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("t5_hs_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("t5_hs_req_ready", {63'h0, req_ready}, 64'h1);
        chk("t5_hs_alu_op", {60'h0, alu_op}, 64'hF);
        step();
        req_valid = 1'b0;
        chk("t5_next_lo_op", {60'h0, alu_op}, 64'h8);
        chk("t5_next_lo_a",  {32'h0, alu_a}, 64'h1);
        step();
        chk("t5_next_result", rsp_result, 64'h0000_0000_FFFF_FFFF);
        chk("t5_next_flags", {60'h0, flags}, 64'hA);
        handshake("t5n");

        // 6: reset during the HI pass abandons the operation
        accept(4'b0111, 1'b1, 1'b1, 64'hFFFF_FFFF, 64'h1, "t6");
        step();
        chk("t6_in_hi_op", {60'h0, alu_op}, 64'h9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        chk("t6_rst_req_ready", {63'h0, req_ready}, 64'h1);
        chk("t6_rst_flags", {60'h0, flags}, 64'h0);
        chk("t6_rst_result", rsp_result, 64'h0);
        chk("t6_rst_alu_op", {60'h0, alu_op}, 64'hF);
        chk("t6_rst_alu_a", {32'h0, alu_a}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        accept(4'b0111, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0002, 64'h1234_5678_0000_0003, "t7");
        step();
        chk("t7_rsp_valid", {63'h0, rsp_valid}, 64'h1);
        chk("t7_result", rsp_result, 64'h5);
        chk("t7_rsp_flags", {60'h0, rsp_flags}, 64'h0);
        chk("t7_flags", {60'h0, flags}, 64'h0);
        handshake("t7");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_alu_wide_sequencer

// File: doc/alu_wide_sequencer.md
Name: alu_wide_sequencer

Overview:
- Multi-cycle controller in front of the shared 32-bit combinational ALU.
- Accepts 32- or 64-bit operations over a valid/ready request channel and drives the ALU for one pass (narrow) or two passes (wide: low word, then high word with carry/borrow chained).
- Owns the architectural NZCV flag register and returns the result plus flags over a valid/ready response channel.

Parameters:
- IDLE_OP, 4'b1111, ALU op driven when no pass is active (ALU default: pass A through).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  4  ALU op code (0000..1010 as defined for the ALU).
- req_wide  in  1  1 = 64-bit operation.
- req_setf  in  1  1 = update the NZCV register.
- req_a, req_b  in  64 each  operands; bit 0 = MSB, matching ALU ordering. Only the low 32 bits are used when req_wide=0.
- alu_a, alu_b  out  32 each  to ALU A, B.
- alu_op  out  4  to ALU OP.
- alu_cin  out  1  to ALU Cin.
- alu_o  in  32  ALU result.
- alu_n, alu_z, alu_v, alu_cout  in  1 each  ALU flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  64  result; upper word 0 when narrow.
- rsp_flags  out  4  NZCV computed for this op, regardless of req_setf.
- flags  out  4  architectural NZCV register.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - rsp_valid=0, rsp_result=0, rsp_flags=0, flags=0.
  - Operand registers cleared.
  - ALU drive: alu_a=0, alu_b=0, alu_op=IDLE_OP, alu_cin=0.
  - A reset mid-operation abandons the operation; flags are not updated.
- States: IDLE, LO, HI, RESP.
  - IDLE: req_ready=1. On req_valid, latch op, wide, setf, a, b; go to LO.
  - LO: drive the low words; capture alu_o and flags at the clock edge. Go to HI if wide, else RESP.
  - HI: drive the high words; capture alu_o and flags. Go to RESP.
  - RESP: rsp_valid=1. Result and flags are held stable until rsp_ready=1, then return to IDLE.
- Latency from the acceptance edge to rsp_valid: narrow 2 cycles, wide 3 cycles.
- req_ready=0 in LO, HI and RESP. No overlap; the earliest next acceptance is the cycle after the response handshake.
- In IDLE and RESP the ALU is driven with IDLE_OP, zero operands, cin=0.
- Pass op/cin mapping (flag C is the stored architectural C at acceptance):
  - ADD 0111: LO=0111 cin=0; HI=1001 cin=cout_lo.
  - ADC 1001: LO=1001 cin=C; HI=1001 cin=cout_lo.
  - SUB 1000: LO=1000 cin=0; HI=1010 cin=cout_lo (cout is borrow).
  - SBC 1010: LO=1010 cin=C; HI=1010 cin=cout_lo.
  - Narrow: LO only, same LO column.
  - Logic/other ops (0000-0110, 1011-1111): same op in every pass, cin=0.
- Flag composition:
  - Narrow: NZCV taken from the LO pass.
  - Wide: N, V, C from the HI pass; Z = z_lo AND z_hi.
  - C for non-arithmetic ops (anything outside 0111-1010): retains the current architectural C.
- Flag register update:
  - Updated with the composed NZCV at the edge that enters RESP, only if setf=1.
  - With setf=0, flags are unchanged but rsp_flags still reports the composed value.
- rsp_result: {hi_word, lo_word} for wide; {32'h0, lo_word} for narrow.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU op code localparams (AND_L, AND_B, OR_L, OR_B, XOR, XOR_B, ADD, SUB, ADC, SBC).
  - State encoding.
  - NZCV bit index constants.
  - Function mapping (op, pass, C, cout_lo) to (alu_op, alu_cin).
- No sub-module required. The sequencer instantiates nothing; ALU hookup is done at the parent level.

Test Plan:
- Wide ADD a=64'h0000_0000_FFFF_FFFF, b=64'h1, setf=1 -> rsp_result=64'h0000_0001_0000_0000; HI pass alu_op=1001, alu_cin=1; NZCV=0000; rsp_valid 3 cycles after acceptance.
- Wide SUB a=0, b=1, setf=1 -> rsp_result=64'hFFFF_FFFF_FFFF_FFFF; N=1 Z=0 C=1 V=0; flags updated.
- Flags C=1, narrow ADC a=5, b=6 -> rsp_result=12; LO alu_cin=1; rsp_valid 2 cycles after acceptance.
- Wide bitwise AND (0001) a=64'h1_0000_0000, b=64'h0000_0000_FFFF_FFFF, setf=0 -> result 0; rsp_flags Z=1; flags register unchanged.
- Hold rsp_ready=0 for 4 cycles -> rsp_valid, result and flags stable; req_ready=0; a new req_valid is ignored until the handshake completes.
- Assert rst_n=0 during HI -> immediate IDLE; rsp_valid=0; flags=0; the next request completes normally.
